wb_slave_demux: RTL and testbench

WB_SLAVE_DEMUX -- requirements
Module: wb_slave_demux

---
 rtl/wb_slave_demux_pkg.sv | 15 +
 rtl/wb_slave_demux_timer.sv | 34 +++
 rtl/wb_slave_demux.sv | 144 ++++++++++++++
 tb/tb_wb_slave_demux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_demux_pkg.sv
// rtl/wb_slave_demux_pkg.sv - shared types and constants for the Wishbone slave demultiplexer
package wb_slave_demux_pkg;

  localparam int DATA_W = 32;
  localparam int PAGE_W = 20;
  localparam int MAX_SLV = 16;
  localparam logic [PAGE_W-1:0] DEF_BASE_PAGE = 20'h30001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/wb_slave_demux_timer.sv
// rtl/wb_slave_demux_timer.sv - ack-wait cycle counter, used only with WB_SLAVE_DEMUX_TIMEOUT_EN
module wb_slave_demux_timer #(
  parameter int TO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == 16'(TO_CYC));

  // Holds at TO_CYC so the count never wraps while the FSM reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_slave_demux.sv
// rtl/wb_slave_demux.sv - Wishbone classic page-decoding slave demux; WB_SLAVE_DEMUX_TIMEOUT_EN adds an ack timeout
module wb_slave_demux
  import wb_slave_demux_pkg::*;
#(
  parameter int                NSLV      = 5,
  parameter logic [PAGE_W-1:0] BASE_PAGE = DEF_BASE_PAGE,
  parameter int                TO_CYC    = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [DATA_W-1:0]      wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic [DATA_W-1:0]      wbs_dat_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_adr_o,
  output logic [DATA_W-1:0]      s_dat_o,
  output logic [NSLV-1:0]        s_stb_o,
  input  logic [NSLV-1:0]        s_ack_i,
  input  logic [NSLV*DATA_W-1:0] s_dat_i,
  input  logic [NSLV-1:0]        s_irq_i,
  output logic                   irq_o
);

  localparam int PAD_W = MAX_SLV * DATA_W;
  localparam logic [PAGE_W-1:0] NSLV_P = PAGE_W'(NSLV);

  if (NSLV < 1 || NSLV > MAX_SLV || TO_CYC < 1 || TO_CYC > 65535) begin : g_param_check
    $error("wb_slave_demux: NSLV or TO_CYC out of range");
  end

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic [PAGE_W-1:0]   page_off;
  logic                page_hit;
  logic [MAX_SLV-1:0]  ack_pad;
  logic [PAD_W-1:0]    dat_pad;
  logic [DATA_W-1:0]   sel_dat;
  logic                to_expired;

  assign s_we_o  = wbs_we_i;
  assign s_sel_o = wbs_sel_i;
  assign s_adr_o = wbs_adr_i;
  assign s_dat_o = wbs_dat_i;
  assign irq_o   = |s_irq_i;

  // An address below BASE_PAGE wraps to a large offset and misses.
  assign page_off = wbs_adr_i[31:12] - BASE_PAGE;
  assign page_hit = (page_off < NSLV_P);

  assign ack_pad = MAX_SLV'(s_ack_i);
  assign dat_pad = PAD_W'(s_dat_i);
  assign sel_dat = dat_pad[{idx_q, 5'd0} +: DATA_W];

  // Strobe is decoded from state so an async reset removes it immediately.
  assign s_stb_o = (state_q == ST_ACTIVE) ? NSLV'(16'd1 << idx_q) : '0;

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

`ifdef WB_SLAVE_DEMUX_TIMEOUT_EN
  wb_slave_demux_timer #(
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .en_i      (state_q == ST_ACTIVE),
    .clr_i     ((state_q == ST_IDLE) && (state_d == ST_ACTIVE)),
    .expired_o (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (page_hit) begin
            idx_d   = page_off[3:0];
            state_d = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACTIVE: begin
        // Abort outranks a same-cycle ack or timeout.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_pad[idx_q]) begin
          ack_d   = 1'b1;
          dat_d   = wbs_we_i ? '0 : sel_dat;
          state_d = ST_RESP;
        end else if (to_expired) begin
          err_d   = 1'b1;
          dat_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_slave_demux.sv
// tb/tb_wb_slave_demux.sv - directed self-checking bench for wb_slave_demux (WB_SLAVE_DEMUX_TIMEOUT_EN optional)
module tb_wb_slave_demux;

  localparam int NSLV = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cyc = 1'b0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [3:0]      sel = 4'hF;
  logic [31:0]     adr = '0;
  logic [31:0]     wdat = 32'h1234_5678;
  logic            ack_o, err_o;
  logic [31:0]     dat_o;
  logic            s_we;
  logic [3:0]      s_sel;
  logic [31:0]     s_adr, s_dat_fwd;
  logic [NSLV-1:0] s_stb;
  logic [NSLV-1:0] s_ack = '0;
  logic [NSLV*32-1:0] s_dat = '0;
  logic [NSLV-1:0] s_irq = '0;
  logic            irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_slave_demux #(
    .NSLV      (NSLV),
    .BASE_PAGE (20'h30001),
    .TO_CYC    (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack_o),
    .wbs_err_o (err_o),
    .wbs_dat_o (dat_o),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat_fwd),
    .s_stb_o   (s_stb),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_dat),
    .s_irq_i   (s_irq),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic outs_idle(input string tag, input logic [31:0] exp_dat);
    chk({tag, " stb"}, 32'(s_stb), 32'h0);
    chk({tag, " ack"}, 32'(ack_o), 32'h0);
    chk({tag, " err"}, 32'(err_o), 32'h0);
    chk({tag, " dat"}, dat_o, exp_dat);
  endtask

  initial begin
    int err_cyc;
    bit ack_seen;

    for (int k = 0; k < NSLV; k++) s_dat[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);

    step();
    step();
    outs_idle("reset", 32'h0);
    rst = 1'b0;
    step();

    // read slave 2, ack in cycle 3
    s_dat[64 +: 32] = 32'hA5A5_0002;
    adr = 32'h3000_3010; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    chk("rd c0 stb", 32'(s_stb), 32'h0);
    chk("fwd adr", s_adr, 32'h3000_3010);
    chk("fwd wdat", s_dat_fwd, 32'h1234_5678);
    step();
    chk("rd c1 stb", 32'(s_stb), 32'h04);
    step();
    chk("rd c2 stb", 32'(s_stb), 32'h04);
    chk("rd c2 ack", 32'(ack_o), 32'h0);
    step();
    s_ack = 5'b00100;
    chk("rd c3 ack", 32'(ack_o), 32'h0);
    step();
    s_ack = '0;
    chk("rd c4 ack", 32'(ack_o), 32'h1);
    chk("rd c4 err", 32'(err_o), 32'h0);
    chk("rd c4 dat", dat_o, 32'hA5A5_0002);
    chk("rd c4 stb", 32'(s_stb), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    step();
    outs_idle("rd c5", 32'hA5A5_0002);

    // unmapped page above the window
    adr = 32'h3000_9000; cyc = 1'b1; stb = 1'b1;
    step();
    chk("hi err", 32'(err_o), 32'h1);
    chk("hi ack", 32'(ack_o), 32'h0);
    chk("hi stb", 32'(s_stb), 32'h0);
    chk("hi dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    step();
    outs_idle("hi after", 32'h0);

    // unmapped page just below the window
    adr = 32'h3000_0000; cyc = 1'b1; stb = 1'b1;
    step();
    chk("lo err", 32'(err_o), 32'h1);
    cyc = 1'b0; stb = 1'b0;
    step();

    // acks while idle are ignored
    s_ack = '1;
    step();
    step();
    outs_idle("idle ack", 32'h0);
    s_ack = '0;

    // slave 1 selected, slave 0 acks spuriously first
    s_dat[32 +: 32] = 32'h1111_2222;
    adr = 32'h3000_2004; cyc = 1'b1; stb = 1'b1;
    step();
    chk("sp c1 stb", 32'(s_stb), 32'h02);
    s_ack = 5'b00001;
    step();
    chk("sp c2 ack", 32'(ack_o), 32'h0);
    chk("sp c2 stb", 32'(s_stb), 32'h02);
    s_ack = 5'b00010;
    step();
    s_ack = '0;
    chk("sp c3 ack", 32'(ack_o), 32'h1);
    chk("sp c3 dat", dat_o, 32'h1111_2222);
    cyc = 1'b0; stb = 1'b0;
    step();

    // reset in ACTIVE drops strobe immediately
    adr = 32'h3000_4000; cyc = 1'b1; stb = 1'b1;
    step();
    chk("rs stb pre", 32'(s_stb), 32'h08);
    rst = 1'b1;
    #1;
    outs_idle("rs async", 32'h0);
    cyc = 1'b0; stb = 1'b0;
    step();
    outs_idle("rs held", 32'h0);
    rst = 1'b0;
    step();

    // write to slave 0 returns zero data
    s_dat[0 +: 32] = 32'hFFFF_FFFF;
    adr = 32'h3000_1008; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    chk("fwd we", 32'(s_we), 32'h1);
    step();
    chk("wr stb", 32'(s_stb), 32'h01);
    s_ack = 5'b00001;
    step();
    s_ack = '0;
    chk("wr ack", 32'(ack_o), 32'h1);
    chk("wr dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();

    // last slave, abort with same-cycle ack
    adr = 32'h3000_5000; cyc = 1'b1; stb = 1'b1;
    step();
    chk("ab stb", 32'(s_stb), 32'h10);
    cyc = 1'b0; stb = 1'b0; s_ack = 5'b10000;
    step();
    s_ack = '0;
    outs_idle("ab c2", 32'h0);
    step();
    outs_idle("ab c3", 32'h0);

    // interrupt OR
    chk("irq none", 32'(irq), 32'h0);
    s_irq = 5'b01000;
    #1;
    chk("irq one", 32'(irq), 32'h1);
    s_irq = '0;
    #1;
    chk("irq clr", 32'(irq), 32'h0);

    // slave never acks
    adr = 32'h3000_3000; cyc = 1'b1; stb = 1'b1;
    err_cyc = -1;
    ack_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ack_o) ack_seen = 1'b1;
      if (err_o && err_cyc < 0) err_cyc = c;
    end
    chk("nack ack", 32'(ack_seen), 32'h0);
`ifdef WB_SLAVE_DEMUX_TIMEOUT_EN
    chk("to err cyc", 32'(err_cyc), 32'd10);
    cyc = 1'b0; stb = 1'b0;
    step();
`else
    chk("wait err", 32'(err_cyc), 32'hFFFF_FFFF);
    chk("wait stb", 32'(s_stb), 32'h04);
    cyc = 1'b0; stb = 1'b0;
    step();
    outs_idle("wait abort", 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
